irq_pending_latch: RTL and testbench

- Upstream stage of the 4-input priority encoder: synchronizes four asynchronous request lines, latches them as pending bits, applies a mask, and drives the encoder inputs y0..y3.
- Reads back the encoder's valid flag and 2-bit code (v, d1:d0).
- Presents the winning index to a consumer through a req/ack handshake.
- Clears the serviced pending bit on acknowledge.

---
 rtl/irq_pending_latch_if.sv | 29 ++
 rtl/irq_pending_latch.sv | 180 ++++++++++++++++++
 tb/tb_irq_pending_latch.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_pending_latch_if.sv
// Bus between the pending latch, the 4-input priority encoder and the consumer.
// The encoder side carries y, v_in and d_in. The consumer side carries irq_req, irq_id and irq_ack.
// The master modport is the latch's view of the bus. The slave modport is the environment's view.
interface irq_pending_latch_if;
   logic [3:0] y;
   logic       v_in;
   logic [1:0] d_in;
   logic       irq_req;
   logic [1:0] irq_id;
   logic       irq_ack;

   modport master (
      output y,
      input  v_in,
      input  d_in,
      output irq_req,
      output irq_id,
      input  irq_ack
   );

   modport slave (
      input  y,
      output v_in,
      output d_in,
      input  irq_req,
      input  irq_id,
      output irq_ack
   );
endinterface

// File: rtl/irq_pending_latch.sv
// irq_pending_latch
//   Synchronizes four asynchronous request lines and latches them as pending bits.
//   It masks the pending bits onto the encoder inputs and reads back the encoder's valid flag and code.
//   It offers the winning index to a consumer over a req/ack handshake.
//   The serviced pending bit is cleared on acknowledge.
//   A request that waits TIMEOUT cycles without ack is abandoned and flagged.
module irq_pending_latch #(
   parameter int unsigned EDGE_MODE = 1,
   parameter int unsigned TIMEOUT   = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [3:0]                irq_in,
   input  logic [3:0]                mask,
   output logic [3:0]                overrun,
   output logic                      timeout,
   irq_pending_latch_if.master       bus
);

   localparam bit         EDGE_EN = (EDGE_MODE != 0);
   localparam bit         TO_EN   = (TIMEOUT != 0);
   localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // One-hot decode of a 2-bit line index into a 4-bit clear vector.
   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      logic [3:0] res;
      case (idx)
         2'd0:    res = 4'b0001;
         2'd1:    res = 4'b0010;
         2'd2:    res = 4'b0100;
         2'd3:    res = 4'b1000;
         default: res = 4'b0000;
      endcase
      return res;
   endfunction

   // Synchronizer chain and edge detect.
   logic [3:0] r_s1;
   logic [3:0] r_s2;
   logic [3:0] r_s3;
   logic [3:0] w_rise;
   logic [3:0] w_set;

   // Pending and sticky status.
   logic [3:0] r_pending;
   logic [3:0] r_overrun;
   logic [3:0] w_clr;
   logic [3:0] w_ovr_hit;
   logic       r_timeout;
   logic       w_timeout_nx;

   // Handshake FSM state.
   state_t     r_state;
   state_t     w_state_nx;
   logic       r_irq_req;
   logic       w_irq_req_nx;
   logic [1:0] r_irq_id;
   logic [1:0] w_irq_id_nx;
   logic [7:0] r_cnt;
   logic [7:0] w_cnt_nx;

   // Three-flop synchronizer per line. s1 may go metastable. s2 and s3 are clean samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 4'b0000;
         r_s2 <= 4'b0000;
         r_s3 <= 4'b0000;
      end else begin
         r_s1 <= irq_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_rise = r_s2 & ~r_s3;
   // In edge mode a line is captured once per rising edge. In level mode it is captured while high.
   assign w_set = EDGE_EN ? w_rise : r_s2;
   // Overrun is a fresh edge on a line whose pending bit survives this cycle. It exists only in edge mode.
   assign w_ovr_hit = EDGE_EN ? (w_rise & r_pending & ~w_clr) : 4'b0000;

   // Pending bits: set wins over the ack-driven clear in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= 4'b0000;
      end else begin
         r_pending <= (r_pending & ~w_clr) | w_set;
      end
   end

   // Sticky overrun flags, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overrun <= 4'b0000;
      end else begin
         r_overrun <= r_overrun | w_ovr_hit;
      end
   end

   // Registered handshake state: FSM state, request, frozen id, wait counter and sticky timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_irq_req <= 1'b0;
         r_irq_id  <= 2'd0;
         r_cnt     <= 8'd0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_irq_req <= w_irq_req_nx;
         r_irq_id  <= w_irq_id_nx;
         r_cnt     <= w_cnt_nx;
         r_timeout <= w_timeout_nx;
      end
   end

   // Next-state logic for the handshake. The ack clear is a combinational pulse taken from the frozen id.
   always_comb begin
      w_state_nx   = r_state;
      w_irq_req_nx = r_irq_req;
      w_irq_id_nx  = r_irq_id;
      w_cnt_nx     = r_cnt;
      w_timeout_nx = r_timeout;
      w_clr        = 4'b0000;
      case (r_state)
         ST_IDLE: begin
            if (bus.v_in) begin
               w_irq_id_nx  = bus.d_in;
               w_cnt_nx     = 8'd0;
               w_irq_req_nx = 1'b1;
               w_state_nx   = ST_REQ;
            end else begin
               w_irq_req_nx = 1'b0;
            end
         end
         ST_REQ: begin
            w_irq_req_nx = 1'b1;
            if (bus.irq_ack) begin
               // Ack has priority over a simultaneous expiry.
               w_clr        = onehot4(r_irq_id);
               w_irq_req_nx = 1'b0;
               w_state_nx   = ST_HOLD;
            end else if (TO_EN && (r_cnt == TO_LAST)) begin
               // Abandon the request. The pending bit stays set so the line is offered again.
               w_timeout_nx = 1'b1;
               w_irq_req_nx = 1'b0;
               w_state_nx   = ST_HOLD;
            end else begin
               // Saturate rather than wrap when the timeout is disabled.
               if (r_cnt != 8'hFF) begin
                  w_cnt_nx = r_cnt + 8'd1;
               end else begin
                  w_cnt_nx = r_cnt;
               end
            end
         end
         ST_HOLD: begin
            // Dead cycle so the encoder output reflects the cleared pending bit before IDLE samples it.
            w_irq_req_nx = 1'b0;
            w_state_nx   = ST_IDLE;
         end
         default: begin
            w_irq_req_nx = 1'b0;
            w_state_nx   = ST_IDLE;
         end
      endcase
   end

   assign bus.y       = r_pending & ~mask;
   assign bus.irq_req = r_irq_req;
   assign bus.irq_id  = r_irq_id;
   assign overrun     = r_overrun;
   assign timeout     = r_timeout;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed testbench for irq_pending_latch.
// dut_a uses edge mode with a timeout of 4 cycles. dut_b uses level mode with the timeout disabled.
// A behavioural 4-input priority encoder closes the loop from y back to v_in and d_in.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_irq_pending_latch;

   logic       clk;
   logic       rst_n;
   logic [3:0] irq_in_a;
   logic [3:0] mask_a;
   logic [3:0] overrun_a;
   logic       timeout_a;
   logic [3:0] irq_in_b;
   logic [3:0] mask_b;
   logic [3:0] overrun_b;
   logic       timeout_b;
   int         n_chk;
   int         n_fail;

   irq_pending_latch_if if_a ();
   irq_pending_latch_if if_b ();

   irq_pending_latch #(.EDGE_MODE(1), .TIMEOUT(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .irq_in(irq_in_a), .mask(mask_a),
      .overrun(overrun_a), .timeout(timeout_a), .bus(if_a)
   );

   irq_pending_latch #(.EDGE_MODE(0), .TIMEOUT(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .irq_in(irq_in_b), .mask(mask_b),
      .overrun(overrun_b), .timeout(timeout_b), .bus(if_b)
   );

   // Priority encoders: the highest set input wins.
   assign if_a.v_in = |if_a.y;
   assign if_a.d_in = if_a.y[3] ? 2'd3 : if_a.y[2] ? 2'd2 : if_a.y[1] ? 2'd1 : 2'd0;
   assign if_b.v_in = |if_b.y;
   assign if_b.d_in = if_b.y[3] ? 2'd3 : if_b.y[2] ? 2'd2 : if_b.y[1] ? 2'd1 : 2'd0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; irq_in_a = 4'b0000; mask_a = 4'b0000; if_a.irq_ack = 1'b0;
      irq_in_b = 4'b0000; mask_b = 4'b0000; if_b.irq_ack = 1'b0;
      repeat (3) tick();
      n_chk++; if (if_a.y !== 4'b0000) begin n_fail++; $display("FAIL reset_y: got %b want 0000", if_a.y); end
      n_chk++; if (if_a.irq_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", if_a.irq_req); end
      n_chk++; if (if_a.irq_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", if_a.irq_id); end
      n_chk++; if (overrun_a !== 4'b0000) begin n_fail++; $display("FAIL reset_ovr: got %b want 0000", overrun_a); end
      n_chk++; if (timeout_a !== 1'b0) begin n_fail++; $display("FAIL reset_to: got %b want 0", timeout_a); end
      rst_n = 1'b1;
      repeat (2) tick();
      n_chk++; if (if_a.irq_req !== 1'b0) begin n_fail++; $display("FAIL reset_idle_req: got %b want 0", if_a.irq_req); end
   endtask

   task automatic test_basic();
      irq_in_a = 4'b0001;
      tick(); tick();
      n_chk++; if (if_a.y !== 4'b0000) begin n_fail++; $display("FAIL basic_y_e2: got %b want 0000", if_a.y); end
      tick();
      n_chk++; if (if_a.y !== 4'b0001) begin n_fail++; $display("FAIL basic_y_e3: got %b want 0001", if_a.y); end
      n_chk++; if (if_a.irq_req !== 1'b0) begin n_fail++; $display("FAIL basic_req_e3: got %b want 0", if_a.irq_req); end
      tick();
      n_chk++; if (if_a.irq_req !== 1'b1) begin n_fail++; $display("FAIL basic_req_e4: got %b want 1", if_a.irq_req); end
      n_chk++; if (if_a.irq_id !== 2'd0) begin n_fail++; $display("FAIL basic_id_e4: got %0d want 0", if_a.irq_id); end
      if_a.irq_ack = 1'b1; tick(); if_a.irq_ack = 1'b0;
      n_chk++; if (if_a.y !== 4'b0000) begin n_fail++; $display("FAIL basic_y_ack: got %b want 0000", if_a.y); end
      n_chk++; if (if_a.irq_req !== 1'b0) begin n_fail++; $display("FAIL basic_req_ack: got %b want 0", if_a.irq_req); end
      tick();
      n_chk++; if (if_a.irq_req !== 1'b0) begin n_fail++; $display("FAIL basic_req_hold: got %b want 0", if_a.irq_req); end
      tick();
      n_chk++; if (if_a.irq_req !== 1'b0) begin n_fail++; $display("FAIL basic_req_idle: got %b want 0", if_a.irq_req); end
      irq_in_a = 4'b0000; repeat (3) tick();
   endtask

   task automatic test_back_to_back();
      irq_in_a = 4'b1010;
      repeat (3) tick();
      n_chk++; if (if_a.y !== 4'b1010) begin n_fail++; $display("FAIL b2b_y: got %b want 1010", if_a.y); end
      tick();
      n_chk++; if (if_a.irq_req !== 1'b1) begin n_fail++; $display("FAIL b2b_req1: got %b want 1", if_a.irq_req); end
      n_chk++; if (if_a.irq_id !== 2'd3) begin n_fail++; $display("FAIL b2b_id1: got %0d want 3", if_a.irq_id); end
      if_a.irq_ack = 1'b1; tick(); if_a.irq_ack = 1'b0;
      n_chk++; if (if_a.y !== 4'b0010) begin n_fail++; $display("FAIL b2b_y_ack: got %b want 0010", if_a.y); end
      n_chk++; if (if_a.irq_req !== 1'b0) begin n_fail++; $display("FAIL b2b_req_ack: got %b want 0", if_a.irq_req); end
      tick();
      n_chk++; if (if_a.irq_req !== 1'b0) begin n_fail++; $display("FAIL b2b_req_hold: got %b want 0", if_a.irq_req); end
      tick();
      n_chk++; if (if_a.irq_req !== 1'b1) begin n_fail++; $display("FAIL b2b_req2: got %b want 1", if_a.irq_req); end
      n_chk++; if (if_a.irq_id !== 2'd1) begin n_fail++; $display("FAIL b2b_id2: got %0d want 1", if_a.irq_id); end
      if_a.irq_ack = 1'b1; tick(); if_a.irq_ack = 1'b0;
      n_chk++; if (if_a.y !== 4'b0000) begin n_fail++; $display("FAIL b2b_y_end: got %b want 0000", if_a.y); end
      irq_in_a = 4'b0000; repeat (3) tick();
   endtask

   task automatic test_mask();
      mask_a = 4'b1000; irq_in_a = 4'b1000;
      repeat (3) tick();
      n_chk++; if (if_a.y !== 4'b0000) begin n_fail++; $display("FAIL mask_y: got %b want 0000", if_a.y); end
      tick(); tick();
      n_chk++; if (if_a.irq_req !== 1'b0) begin n_fail++; $display("FAIL mask_req: got %b want 0", if_a.irq_req); end
      mask_a = 4'b0000; #1;
      n_chk++; if (if_a.y !== 4'b1000) begin n_fail++; $display("FAIL mask_y_open: got %b want 1000", if_a.y); end
      tick();
      n_chk++; if (if_a.irq_req !== 1'b1) begin n_fail++; $display("FAIL mask_req_open: got %b want 1", if_a.irq_req); end
      n_chk++; if (if_a.irq_id !== 2'd3) begin n_fail++; $display("FAIL mask_id: got %0d want 3", if_a.irq_id); end
      mask_a = 4'b1000; tick();
      n_chk++; if (if_a.irq_req !== 1'b1) begin n_fail++; $display("FAIL mask_req_frozen: got %b want 1", if_a.irq_req); end
      n_chk++; if (if_a.irq_id !== 2'd3) begin n_fail++; $display("FAIL mask_id_frozen: got %0d want 3", if_a.irq_id); end
      if_a.irq_ack = 1'b1; tick(); if_a.irq_ack = 1'b0;
      mask_a = 4'b0000; #1;
      n_chk++; if (if_a.y !== 4'b0000) begin n_fail++; $display("FAIL mask_y_clr: got %b want 0000", if_a.y); end
      irq_in_a = 4'b0000; repeat (3) tick();
   endtask

   task automatic test_overrun();
      // Two pulses on line 2 before ack: one service clears it, overrun records the second edge.
      irq_in_a = 4'b0100; tick(); irq_in_a = 4'b0000; tick();
      irq_in_a = 4'b0100; tick();
      n_chk++; if (if_a.y !== 4'b0100) begin n_fail++; $display("FAIL ovr_y: got %b want 0100", if_a.y); end
      n_chk++; if (overrun_a !== 4'b0000) begin n_fail++; $display("FAIL ovr_first: got %b want 0000", overrun_a); end
      irq_in_a = 4'b0000; tick();
      n_chk++; if (if_a.irq_id !== 2'd2) begin n_fail++; $display("FAIL ovr_id: got %0d want 2", if_a.irq_id); end
      tick();
      n_chk++; if (overrun_a !== 4'b0100) begin n_fail++; $display("FAIL ovr_set: got %b want 0100", overrun_a); end
      if_a.irq_ack = 1'b1; tick(); if_a.irq_ack = 1'b0;
      n_chk++; if (if_a.y !== 4'b0000) begin n_fail++; $display("FAIL ovr_y_clr: got %b want 0000", if_a.y); end
      tick(); tick();
      n_chk++; if (if_a.irq_req !== 1'b0) begin n_fail++; $display("FAIL ovr_no_rereq: got %b want 0", if_a.irq_req); end
      // Second edge lands in the ack cycle: set wins, line is re-requested.
      irq_in_a = 4'b0100; tick(); irq_in_a = 4'b0000; tick(); tick();
      irq_in_a = 4'b0100; tick();
      n_chk++; if (if_a.irq_req !== 1'b1) begin n_fail++; $display("FAIL ovr2_req: got %b want 1", if_a.irq_req); end
      irq_in_a = 4'b0000; tick();
      if_a.irq_ack = 1'b1; tick(); if_a.irq_ack = 1'b0;
      n_chk++; if (if_a.y !== 4'b0100) begin n_fail++; $display("FAIL ovr2_y_kept: got %b want 0100", if_a.y); end
      n_chk++; if (if_a.irq_req !== 1'b0) begin n_fail++; $display("FAIL ovr2_req_ack: got %b want 0", if_a.irq_req); end
      tick(); tick();
      n_chk++; if (if_a.irq_req !== 1'b1 || if_a.irq_id !== 2'd2) begin n_fail++; $display("FAIL ovr2_rereq: got req=%b id=%0d want req=1 id=2", if_a.irq_req, if_a.irq_id); end
      if_a.irq_ack = 1'b1; tick(); if_a.irq_ack = 1'b0;
      n_chk++; if (if_a.y !== 4'b0000) begin n_fail++; $display("FAIL ovr2_y_end: got %b want 0000", if_a.y); end
      n_chk++; if (overrun_a !== 4'b0100) begin n_fail++; $display("FAIL ovr_sticky: got %b want 0100", overrun_a); end
      tick(); tick();
   endtask

   task automatic test_ack_at_expiry();
      irq_in_a = 4'b0001;
      repeat (4) tick();
      repeat (3) tick();
      n_chk++; if (if_a.irq_req !== 1'b1) begin n_fail++; $display("FAIL ackexp_req: got %b want 1", if_a.irq_req); end
      if_a.irq_ack = 1'b1; tick(); if_a.irq_ack = 1'b0;
      n_chk++; if (timeout_a !== 1'b0) begin n_fail++; $display("FAIL ackexp_to: got %b want 0", timeout_a); end
      n_chk++; if (if_a.y !== 4'b0000) begin n_fail++; $display("FAIL ackexp_y: got %b want 0000", if_a.y); end
      n_chk++; if (if_a.irq_req !== 1'b0) begin n_fail++; $display("FAIL ackexp_req_end: got %b want 0", if_a.irq_req); end
      irq_in_a = 4'b0000; repeat (3) tick();
   endtask

   task automatic test_timeout();
      irq_in_a = 4'b0001;
      repeat (4) tick();
      n_chk++; if (if_a.irq_req !== 1'b1) begin n_fail++; $display("FAIL to_req_c0: got %b want 1", if_a.irq_req); end
      for (int i = 1; i < 4; i++) begin
         tick();
         n_chk++; if (if_a.irq_req !== 1'b1) begin n_fail++; $display("FAIL to_req_c%0d: got %b want 1", i, if_a.irq_req); end
      end
      tick();
      n_chk++; if (if_a.irq_req !== 1'b0) begin n_fail++; $display("FAIL to_req_drop: got %b want 0", if_a.irq_req); end
      n_chk++; if (timeout_a !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b want 1", timeout_a); end
      n_chk++; if (if_a.y !== 4'b0001) begin n_fail++; $display("FAIL to_pending_kept: got %b want 0001", if_a.y); end
      tick();
      n_chk++; if (if_a.irq_req !== 1'b0) begin n_fail++; $display("FAIL to_req_hold: got %b want 0", if_a.irq_req); end
      tick();
      n_chk++; if (if_a.irq_req !== 1'b1 || if_a.irq_id !== 2'd0) begin n_fail++; $display("FAIL to_rereq: got req=%b id=%0d want req=1 id=0", if_a.irq_req, if_a.irq_id); end
      if_a.irq_ack = 1'b1; tick(); if_a.irq_ack = 1'b0;
      n_chk++; if (if_a.y !== 4'b0000) begin n_fail++; $display("FAIL to_y_end: got %b want 0000", if_a.y); end
      irq_in_a = 4'b0000; repeat (3) tick();
   endtask

   task automatic test_async_reset();
      irq_in_a = 4'b0011;
      repeat (4) tick();
      n_chk++; if (if_a.irq_req !== 1'b1 || if_a.irq_id !== 2'd1) begin n_fail++; $display("FAIL arst_pre: got req=%b id=%0d want req=1 id=1", if_a.irq_req, if_a.irq_id); end
      #2; rst_n = 1'b0; #1;
      n_chk++; if (if_a.irq_req !== 1'b0) begin n_fail++; $display("FAIL arst_req: got %b want 0", if_a.irq_req); end
      n_chk++; if (if_a.y !== 4'b0000) begin n_fail++; $display("FAIL arst_y: got %b want 0000", if_a.y); end
      n_chk++; if (overrun_a !== 4'b0000) begin n_fail++; $display("FAIL arst_ovr: got %b want 0000", overrun_a); end
      n_chk++; if (timeout_a !== 1'b0) begin n_fail++; $display("FAIL arst_to: got %b want 0", timeout_a); end
      irq_in_a = 4'b0000;
      tick(); rst_n = 1'b1;
      repeat (4) tick();
      n_chk++; if (if_a.y !== 4'b0000 || if_a.irq_req !== 1'b0) begin n_fail++; $display("FAIL arst_lost: got y=%b req=%b want y=0000 req=0", if_a.y, if_a.irq_req); end
   endtask

   task automatic test_level_mode();
      irq_in_b = 4'b0100;
      repeat (3) tick();
      n_chk++; if (if_b.y !== 4'b0100) begin n_fail++; $display("FAIL lvl_y: got %b want 0100", if_b.y); end
      tick();
      n_chk++; if (if_b.irq_req !== 1'b1 || if_b.irq_id !== 2'd2) begin n_fail++; $display("FAIL lvl_req: got req=%b id=%0d want req=1 id=2", if_b.irq_req, if_b.irq_id); end
      if_b.irq_ack = 1'b1; tick(); if_b.irq_ack = 1'b0;
      n_chk++; if (if_b.y !== 4'b0100) begin n_fail++; $display("FAIL lvl_reset_wins: got %b want 0100", if_b.y); end
      n_chk++; if (if_b.irq_req !== 1'b0) begin n_fail++; $display("FAIL lvl_req_ack: got %b want 0", if_b.irq_req); end
      tick(); tick();
      n_chk++; if (if_b.irq_req !== 1'b1) begin n_fail++; $display("FAIL lvl_rereq: got %b want 1", if_b.irq_req); end
      repeat (20) tick();
      n_chk++; if (if_b.irq_req !== 1'b1 || timeout_b !== 1'b0) begin n_fail++; $display("FAIL lvl_no_timeout: got req=%b to=%b want req=1 to=0", if_b.irq_req, timeout_b); end
      n_chk++; if (overrun_b !== 4'b0000) begin n_fail++; $display("FAIL lvl_ovr: got %b want 0000", overrun_b); end
      irq_in_b = 4'b0000; repeat (3) tick();
      if_b.irq_ack = 1'b1; tick(); if_b.irq_ack = 1'b0;
      n_chk++; if (if_b.y !== 4'b0000 || if_b.irq_req !== 1'b0) begin n_fail++; $display("FAIL lvl_end: got y=%b req=%b want y=0000 req=0", if_b.y, if_b.irq_req); end
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_mask();
      test_overrun();
      test_ack_at_expiry();
      test_timeout();
      test_async_reset();
      test_level_mode();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Guard against a stalled run.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
